// File: rtl/cmd_phy.sv
// rtl/cmd_phy.sv - SD CMD line PHY: frame transmit with CRC7, response capture/check (optional CMD_PHY_CRC_CHECK_EN)
module cmd_phy #(
    parameter int NCR_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_in,
    input  logic [39:0] cmd_in,
    input  logic        expect_resp,
    output logic        ack_out,
    output logic        req_out,
    input  logic        ack_in,
    output logic [39:0] resp_out,
    output logic        timeout,
    output logic        crc_error,
    output logic        end_error,
    output logic        idle,
    output logic        cmd_pin_out,
    output logic        cmd_oe,
    input  logic        cmd_pin_in
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, CHECK, HANDSHAKE} state_t;

    localparam logic [6:0] NCR_LIMIT = 7'(NCR_TIMEOUT);

    // One serial CRC7 step, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [39:0] cmd_q, cmd_d;
    logic        er_q, er_d;
    logic [6:0]  crc_q, crc_d;
    logic [47:0] rx_q, rx_d;
    logic        ack_q, ack_d;
    logic        req_q, req_d;
    logic        hs_q, hs_d;
    logic [39:0] resp_q, resp_d;
    logic        to_q, to_d;
    logic        end_err_q, end_err_d;
    logic        pin_q, pin_d;
    logic        oe_q, oe_d;
`ifdef CMD_PHY_CRC_CHECK_EN
    logic [6:0]  rcrc_q, rcrc_d;
    logic        crc_err_q, crc_err_d;
`endif

    // Next-state logic for the command/response sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        er_d      = er_q;
        crc_d     = crc_q;
        rx_d      = rx_q;
        ack_d     = ack_q;
        req_d     = req_q;
        hs_d      = hs_q;
        resp_d    = resp_q;
        to_d      = to_q;
        end_err_d = end_err_q;
        pin_d     = pin_q;
        oe_d      = oe_q;
`ifdef CMD_PHY_CRC_CHECK_EN
        rcrc_d    = rcrc_q;
        crc_err_d = crc_err_q;
`endif
        // ack stays up until the controller withdraws its request
        if (ack_q && !req_in) ack_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_in && !ack_q) begin
                    cmd_d     = cmd_in;
                    er_d      = expect_resp;
                    crc_d     = 7'h00;
                    cnt_d     = 7'd0;
                    ack_d     = 1'b1;
                    hs_d      = 1'b0;
                    resp_d    = 40'h0;
                    to_d      = 1'b0;
                    end_err_d = 1'b0;
`ifdef CMD_PHY_CRC_CHECK_EN
                    crc_err_d = 1'b0;
`endif
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (cnt_q < 7'd40) begin
                    // command bits go out MSB first while feeding the CRC
                    pin_d = cmd_q[39];
                    cmd_d = {cmd_q[38:0], 1'b0};
                    crc_d = crc7_step(crc_q, cmd_q[39]);
                    oe_d  = 1'b1;
                    cnt_d = cnt_q + 7'd1;
                end else if (cnt_q < 7'd47) begin
                    pin_d = crc_q[6];
                    crc_d = {crc_q[5:0], 1'b0};
                    cnt_d = cnt_q + 7'd1;
                end else if (cnt_q == 7'd47) begin
                    pin_d = 1'b1;
                    cnt_d = cnt_q + 7'd1;
                end else begin
                    // end bit has had its full cycle: release the line
                    oe_d    = 1'b0;
                    pin_d   = 1'b1;
                    cnt_d   = 7'd1;
                    state_d = er_q ? WAIT_RESP : HANDSHAKE;
                end
            end
            WAIT_RESP: begin
                // start bit takes priority over the timeout on the final count
                if (!cmd_pin_in) begin
                    rx_d    = 48'h0;
                    cnt_d   = 7'd1;
`ifdef CMD_PHY_CRC_CHECK_EN
                    rcrc_d  = 7'h00;
`endif
                    state_d = RECV;
                end else if (cnt_q == NCR_LIMIT) begin
                    to_d    = 1'b1;
                    state_d = HANDSHAKE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            RECV: begin
                rx_d = {rx_q[46:0], cmd_pin_in};
`ifdef CMD_PHY_CRC_CHECK_EN
                if (cnt_q < 7'd40) rcrc_d = crc7_step(rcrc_q, cmd_pin_in);
`endif
                if (cnt_q == 7'd47) state_d = CHECK;
                else                cnt_d   = cnt_q + 7'd1;
            end
            CHECK: begin
                resp_d    = rx_q[47:8];
                end_err_d = ~rx_q[0];
`ifdef CMD_PHY_CRC_CHECK_EN
                crc_err_d = (rx_q[7:1] != rcrc_q);
`endif
                state_d   = HANDSHAKE;
            end
            HANDSHAKE: begin
                if (!hs_q) begin
                    if (req_q && ack_in) begin
                        req_d = 1'b0;
                        hs_d  = 1'b1;
                    end else begin
                        req_d = 1'b1;
                    end
                end else if (!ack_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset releases the CMD line immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 7'd0;
            cmd_q     <= 40'h0;
            er_q      <= 1'b0;
            crc_q     <= 7'h00;
            rx_q      <= 48'h0;
            ack_q     <= 1'b0;
            req_q     <= 1'b0;
            hs_q      <= 1'b0;
            resp_q    <= 40'h0;
            to_q      <= 1'b0;
            end_err_q <= 1'b0;
            pin_q     <= 1'b1;
            oe_q      <= 1'b0;
`ifdef CMD_PHY_CRC_CHECK_EN
            rcrc_q    <= 7'h00;
            crc_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            er_q      <= er_d;
            crc_q     <= crc_d;
            rx_q      <= rx_d;
            ack_q     <= ack_d;
            req_q     <= req_d;
            hs_q      <= hs_d;
            resp_q    <= resp_d;
            to_q      <= to_d;
            end_err_q <= end_err_d;
            pin_q     <= pin_d;
            oe_q      <= oe_d;
`ifdef CMD_PHY_CRC_CHECK_EN
            rcrc_q    <= rcrc_d;
            crc_err_q <= crc_err_d;
`endif
        end
    end

`ifdef CMD_PHY_CRC_CHECK_EN
    assign crc_error = crc_err_q;
`else
    // received CRC field is shifted in but never compared
    logic unused_rx_crc;
    assign unused_rx_crc = ^rx_q[7:1];
    assign crc_error     = 1'b0;
`endif

    assign ack_out     = ack_q;
    assign req_out     = req_q;
    assign resp_out    = resp_q;
    assign timeout     = to_q;
    assign end_error   = end_err_q;
    assign idle        = (state_q == IDLE);
    assign cmd_pin_out = pin_q;
    assign cmd_oe      = oe_q;

endmodule

// File: tb/tb_cmd_phy.sv
// tb/tb_cmd_phy.sv - self-checking bench for cmd_phy
module tb_cmd_phy;

    localparam int NCR = 64;
`ifdef CMD_PHY_CRC_CHECK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_in;
    logic [39:0] cmd_in;
    logic        expect_resp;
    logic        ack_out;
    logic        req_out;
    logic        ack_in;
    logic [39:0] resp_out;
    logic        timeout;
    logic        crc_error;
    logic        end_error;
    logic        idle;
    logic        cmd_pin_out;
    logic        cmd_oe;
    logic        cmd_pin_in;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_phy #(.NCR_TIMEOUT(NCR)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_in      (req_in),
        .cmd_in      (cmd_in),
        .expect_resp (expect_resp),
        .ack_out     (ack_out),
        .req_out     (req_out),
        .ack_in      (ack_in),
        .resp_out    (resp_out),
        .timeout     (timeout),
        .crc_error   (crc_error),
        .end_error   (end_error),
        .idle        (idle),
        .cmd_pin_out (cmd_pin_out),
        .cmd_oe      (cmd_oe),
        .cmd_pin_in  (cmd_pin_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [39:0] cmd;
        logic        er;
        logic        drive;
        int          dly;
        logic [47:0] resp;
        logic [47:0] frame;
        logic [39:0] ro;
        logic        to;
        logic        ce;
        logic        ee;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference CRC7 by mod-2 polynomial division of msg * x^7 by 0x89
    function automatic logic [6:0] crc7_model(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic vec_t mk(input logic [39:0] cmd, input logic er, input logic drive,
                                input int dly, input logic [47:0] resp, input logic [47:0] frame,
                                input logic [39:0] ro, input logic to, input logic ce, input logic ee);
        vec_t v;
        v.cmd = cmd; v.er = er; v.drive = drive; v.dly = dly; v.resp = resp;
        v.frame = frame; v.ro = ro; v.to = to; v.ce = ce; v.ee = ee;
        return v;
    endfunction

    // Issue one command, observe the frame, optionally answer, then complete the handshake
    task automatic run_vec(input vec_t v, input int hold, input string nm);
        logic [47:0] got;
        logic        oe_ok;
        int          w;
        got   = '0;
        oe_ok = 1'b1;
        req_in      = 1'b1;
        cmd_in      = v.cmd;
        expect_resp = v.er;
        @(negedge clock);
        chk({nm, " ack_after_capture"}, ack_out, 1);
        chk({nm, " idle_low"}, idle, 0);
        if (hold == 0) req_in = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clock);
            got[47 - i] = cmd_pin_out;
            if (!cmd_oe) oe_ok = 1'b0;
            if (hold > 0) begin
                if (i == hold - 1) chk({nm, " ack_held"}, ack_out, 1);
                if (i == hold)     req_in = 1'b0;
                if (i == hold + 2) chk({nm, " ack_dropped"}, ack_out, 0);
                if (i == hold + 3) req_in = 1'b1;
                if (i == hold + 4) req_in = 1'b0;
                if (i == hold + 6) chk({nm, " pulse_ignored"}, ack_out, 0);
            end
        end
        chk({nm, " frame"}, got, v.frame);
        chk({nm, " oe_during_send"}, oe_ok, 1);
        @(negedge clock);
        chk({nm, " oe_released"}, cmd_oe, 0);
        chk({nm, " pin_idle_high"}, cmd_pin_out, 1);
        chk({nm, " req_not_yet"}, req_out, 0);
        if (!v.er) begin
            @(negedge clock);
            chk({nm, " req_rise_noresp"}, req_out, 1);
        end else if (v.drive) begin
            repeat (v.dly) @(negedge clock);
            for (int j = 0; j < 48; j++) begin
                cmd_pin_in = v.resp[47 - j];
                @(negedge clock);
            end
            cmd_pin_in = 1'b1;
            @(negedge clock);
            chk({nm, " req_before_s49"}, req_out, 0);
            @(negedge clock);
            chk({nm, " req_at_s49"}, req_out, 1);
        end else begin
            repeat (NCR) @(negedge clock);
            chk({nm, " req_before_timeout"}, req_out, 0);
            @(negedge clock);
            chk({nm, " req_at_timeout"}, req_out, 1);
        end
        chk({nm, " resp_out"}, resp_out, v.ro);
        chk({nm, " timeout"}, timeout, v.to);
        chk({nm, " crc_error"}, crc_error, v.ce);
        chk({nm, " end_error"}, end_error, v.ee);
        ack_in = 1'b1;
        w = 0;
        while (req_out && w < 20) begin @(negedge clock); w++; end
        chk({nm, " req_dropped"}, req_out, 0);
        ack_in = 1'b0;
        w = 0;
        while (!idle && w < 20) begin @(negedge clock); w++; end
        chk({nm, " back_idle"}, idle, 1);
        chk({nm, " flags_held"}, {timeout, crc_error, end_error}, {v.to, v.ce, v.ee});
    endtask

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        logic [39:0] r40;
        logic [47:0] full;
        int          kind;

        tbl[0] = mk(40'h4000000000, 0, 0, 0,  48'h0,            48'h400000000095, 40'h0,          0, 0,      0);
        tbl[1] = mk(40'h48000001AA, 1, 1, 5,  48'h48000001AA87, 48'h48000001AA87, 40'h48000001AA, 0, 0,      0);
        tbl[2] = mk(40'h48000001AA, 1, 1, 5,  48'h48000011AA87, 48'h48000001AA87, 40'h48000011AA, 0, CRC_ON, 0);
        tbl[3] = mk(40'h48000001AA, 1, 1, 5,  48'h48000001AA86, 48'h48000001AA87, 40'h48000001AA, 0, 0,      1);
        tbl[4] = mk(40'h48000001AA, 1, 0, 0,  48'h0,            48'h48000001AA87, 40'h0,          1, 0,      0);
        tbl[5] = mk(40'h48000001AA, 1, 1, 63, 48'h48000001AA87, 48'h48000001AA87, 40'h48000001AA, 0, 0,      0);

        reset = 1'b1; req_in = 1'b0; cmd_in = '0; expect_resp = 1'b0;
        ack_in = 1'b0; cmd_pin_in = 1'b1;
        #1;
        chk("reset cmd_oe", cmd_oe, 0);
        chk("reset cmd_pin_out", cmd_pin_out, 1);
        chk("reset idle", idle, 1);
        chk("reset ack_req", {ack_out, req_out}, 0);
        chk("reset resp_flags", {resp_out, timeout, crc_error, end_error}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int k = 0; k < 6; k++) run_vec(tbl[k], 0, $sformatf("vec%0d", k));

        // CMD17 with ack held for several cycles and a stray request pulse
        run_vec(mk(40'h5100000000, 0, 0, 0, 48'h0, 48'h510000000055, 40'h0, 0, 0, 0), 10, "cmd17");
        repeat (3) @(negedge clock);
        chk("cmd17 no_second_capture", {idle, cmd_oe}, 2'b10);

        // Reset in the middle of SEND
        req_in = 1'b1; cmd_in = 40'h5100000000; expect_resp = 1'b0;
        @(negedge clock);
        req_in = 1'b0;
        repeat (21) @(negedge clock);
        chk("midsend oe_active", cmd_oe, 1);
        #2 reset = 1'b1;
        #1;
        chk("midsend reset cmd_oe", cmd_oe, 0);
        chk("midsend reset pin", cmd_pin_out, 1);
        chk("midsend reset idle", idle, 1);
        chk("midsend reset ack_req", {ack_out, req_out}, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_vec(tbl[0], 0, "cmd0_after_reset");

        // Randomized commands and responses checked against the reference rules
        for (int it = 0; it < 10; it++) begin
            v.cmd   = {2'b01, 6'($urandom_range(0, 63)), 32'($urandom)};
            v.er    = 1'($urandom_range(0, 1));
            v.frame = {v.cmd, crc7_model(v.cmd), 1'b1};
            v.drive = v.er && ($urandom_range(0, 5) != 0);
            v.dly   = int'($urandom_range(0, 63));
            r40     = {2'b00, 6'($urandom_range(0, 63)), 32'($urandom)};
            full    = {r40, crc7_model(r40), 1'b1};
            kind    = int'($urandom_range(0, 3));
            if (kind == 1) full[$urandom_range(1, 46)] ^= 1'b1;
            if (kind == 2) full[0] = 1'b0;
            v.resp  = full;
            v.ro = '0; v.to = 1'b0; v.ce = 1'b0; v.ee = 1'b0;
            if (v.er && !v.drive) begin
                v.to = 1'b1;
            end else if (v.er) begin
                v.ro = full[47:8];
                v.ce = CRC_ON && (full[7:1] != crc7_model(full[47:8]));
                v.ee = ~full[0];
            end
            run_vec(v, 0, $sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_phy.md
# cmd_phy

Serial command physical layer for the SD host. It sits directly downstream of the command controller. It accepts a 40-bit command (start, transmission, index, argument) over a four-phase req/ack handshake, appends CRC7 and the end bit, and shifts the 48-bit frame out on the CMD line one bit per clock. It then optionally captures a 48-bit short response and returns its first 40 bits to the controller over a second four-phase handshake, along with timeout and error status.

## Interface
- NCR_TIMEOUT, 64, maximum number of clocks after the end bit to wait for a response start bit.
- clock  in  1  SD-side clock; one CMD bit per cycle.
- reset  in  1  asynchronous, active-high.
- req_in  in  1  command request from controller; cmd_in and expect_resp are stable while high.
- cmd_in  in  40  command bits 47..8 of the frame, MSB first.
- expect_resp  in  1  1 = wait for a 48-bit response; 0 = no response (e.g. CMD0).
- ack_out  out  1  command accepted.
- req_out  out  1  response/status valid.
- ack_in  in  1  controller has consumed the response.
- resp_out  out  40  response bits 47..8.
- timeout  out  1  no start bit within NCR_TIMEOUT.
- crc_error  out  1  response CRC7 mismatch.
- end_error  out  1  response end bit was 0.
- idle  out  1  block is in IDLE.
- cmd_pin_out  out  1  CMD line drive value.
- cmd_oe  out  1  CMD line output enable.
- cmd_pin_in  in  1  sampled CMD line.

## Operation
- States: IDLE, SEND, WAIT_RESP, RECV, CHECK, HANDSHAKE.
- IDLE: when req_in=1 and ack_out=0, latch cmd_in and expect_resp, clear CRC, and go to SEND.
- ack_out is set on the cycle after capture and is held until req_in is sampled low. Only then is a new request accepted.
- SEND: 48 cycles, MSB first: cmd_in[39:0], then CRC7[6:0], then 1.
  - CRC7 uses polynomial x^7+x^3+1 with initial value 0, computed serially over the 40 command bits.
  - cmd_oe=1 throughout SEND.
- After the end bit:
  - expect_resp=0: go to HANDSHAKE with resp_out=0 and all flags 0.
  - expect_resp=1: go to WAIT_RESP.
- WAIT_RESP: 7-bit counter starting at 1.
  - cmd_pin_in=0 → go to RECV; this start bit counts as response bit 47.
  - Counter reaches NCR_TIMEOUT with no start bit → timeout=1 and go to HANDSHAKE.
- RECV: shift in the remaining 47 bits. CRC7 runs over response bits 47..8.
- CHECK (one cycle):
  - resp_out = bits 47..8.
  - crc_error = (bits 7..1 ≠ computed CRC).
  - end_error = ~bit 0.
  - Go to HANDSHAKE.
- HANDSHAKE: req_out=1 until ack_in=1. Then req_out=0, wait for ack_in=0, then return to IDLE.
- resp_out and all flags hold from CHECK until the next capture.
- reset at any time, including mid-SEND:
  - State returns to IDLE. The CMD line is released within the same cycle (asynchronous).
  - Reset values: cmd_oe=0, cmd_pin_out=1, ack_out=0, req_out=0, resp_out=0, timeout=0, crc_error=0, end_error=0, idle=1.

## Timing
- Capture at edge N. The start bit is driven from edge N+1. The end bit is driven in cycle N+48.
- cmd_oe drops on the edge after the end-bit cycle.
- Response start bit sampled at cycle S: CHECK at S+48, req_out=1 at S+49.
- Timeout: req_out rises NCR_TIMEOUT+1 cycles after cmd_oe falls.
- No-response command: req_out rises on the cycle after cmd_oe falls.
- A start bit sampled in the same cycle the counter hits NCR_TIMEOUT is accepted; the start bit wins.
- idle=1 only in IDLE state.

## Configuration
- CMD_PHY_CRC_CHECK_EN defined:
  - The response CRC7 checker is built.
  - crc_error behaves as described under Operation.
- CMD_PHY_CRC_CHECK_EN undefined:
  - No receive CRC logic is built and crc_error is tied to 0.
  - end_error, timeout, and transmit CRC generation are unaffected.

## Test plan
- CMD0: cmd_in=0x4000000000, expect_resp=0 → line carries 0x400000000095. req_out rises with timeout=0, crc_error=0, end_error=0, resp_out=0.
- CMD17: cmd_in=0x5100000000 → frame 0x510000000055. ack_out is held until req_in drops; a second req_in pulse while ack_out=1 is ignored.
- Response: after CMD8 (frame 0x48000001AA87), the bench drives response 0x48000001AA87 after 5 idle cycles → resp_out=0x48000001AA, crc_error=0, end_error=0.
- Corrupted response: same response with bit 20 flipped → crc_error=1 with the macro defined, 0 without it. Then drive a response with end bit 0 → end_error=1.
- Timeout: expect_resp=1 with cmd_pin_in held at 1 → timeout=1 and req_out=1 exactly NCR_TIMEOUT+1 cycles after cmd_oe falls. A start bit on exactly cycle NCR_TIMEOUT is received normally.
- Reset asserted at bit 20 of SEND → cmd_oe=0 and cmd_pin_out=1 immediately, idle=1. A new CMD0 afterwards produces a clean 0x400000000095 frame.
